// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone round-robin arbiter.
package wb_rr_arbiter_pkg;

    localparam int unsigned ADR_W       = 32;
    localparam int unsigned DAT_W       = 32;
    localparam int unsigned SEL_W       = 4;
    localparam int unsigned DEF_TIMEOUT = 1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } arb_state_e;

    // Tie-break from IDLE: the master that did not own the bus last time wins.
    function automatic arb_state_e rr_pick(input logic last_gnt);
        return last_gnt ? ST_GNT0 : ST_GNT1;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// One Wishbone classic bus segment. The arbiter sees each LM32 master through
// the slave modport and drives the shared downstream port through master.
interface wb_rr_arbiter_if;
    import wb_rr_arbiter_pkg::*;

    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_w;
    logic [DAT_W-1:0] dat_r;
    logic [SEL_W-1:0] sel;
    logic             we;
    logic             cyc;
    logic             stb;
    logic             ack;
    logic             err;

    // Bus initiator view; the downstream interconnect never reports err.
    modport master (
        output adr, dat_w, sel, we, cyc, stb,
        input  dat_r, ack
    );

    // Bus target view.
    modport slave (
        input  adr, dat_w, sel, we, cyc, stb,
        output dat_r, ack, err
    );

endinterface

// File: rtl/wb_rr_arbiter_tmo.sv
// Bus-timeout watchdog counter: clear wins over increment so the count never
// wraps, and tc flags the last cycle a granted strobe may wait for ack.
module wb_rr_arbiter_tmo #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TMO_W   = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [TMO_W-1:0] TC_VAL = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] cnt;

    // Wait counter: cleared on any clr, otherwise counts granted-strobe cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter (LM32 instruction + data buses) in
// front of the address decoder. Grant is locked for the whole cyc; a strobe
// left unacknowledged for TIMEOUT cycles is aborted with err to its master,
// an irq pulse, and the offending address captured for firmware.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no owner, slave sees cyc=stb=0 and zeroed address/data
//  GNT0    | master0 (instruction) owns the slave until it drops cyc
//  GNT1    | master1 (data) owns the slave until it drops cyc
module wb_rr_arbiter
    import wb_rr_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned TMO_W   = $clog2(TIMEOUT)
) (
    input  logic                clk,
    input  logic                reset,
    wb_rr_arbiter_if.slave      m0,
    wb_rr_arbiter_if.slave      m1,
    wb_rr_arbiter_if.master     s,
    output logic                tmo_irq,
    output logic [ADR_W-1:0]    tmo_adr
);

    arb_state_e state;
    arb_state_e state_nxt;
    logic       last_gnt;
    logic       last_gnt_nxt;

    logic       gnt0;
    logic       gnt1;
    logic       gnt_stb;
    logic       tmo_tc;
    logic       tmo_fire;
    logic       tmo_clr;

    assign gnt0    = (state == ST_GNT0);
    assign gnt1    = (state == ST_GNT1);
    assign gnt_stb = (gnt0 & m0.stb) | (gnt1 & m1.stb);

    // A timeout only fires on a live granted strobe; a coincident ack wins.
    assign tmo_fire = gnt_stb & tmo_tc & ~s.ack;
    assign tmo_clr  = ~gnt_stb | s.ack | tmo_fire;

    wb_rr_arbiter_tmo #(
        .TIMEOUT (TIMEOUT),
        .TMO_W   (TMO_W)
    ) u_tmo (
        .clk   (clk),
        .reset (reset),
        .clr   (tmo_clr),
        .inc   (gnt_stb),
        .tc    (tmo_tc)
    );

    // Arbitration state and round-robin history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    // Next grant: cyc-locked ownership, hand over directly when the other waits.
    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        unique case (state)
            ST_IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_nxt = rr_pick(last_gnt);
                end else if (m0.cyc) begin
                    state_nxt = ST_GNT0;
                end else if (m1.cyc) begin
                    state_nxt = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!m0.cyc) begin
                    last_gnt_nxt = 1'b0;
                    state_nxt    = m1.cyc ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (!m1.cyc) begin
                    last_gnt_nxt = 1'b1;
                    state_nxt    = m0.cyc ? ST_GNT0 : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Route the owner to the slave; the abort cycle withdraws cyc/stb.
    always_comb begin
        s.adr   = '0;
        s.dat_w = '0;
        s.sel   = '0;
        s.we    = 1'b0;
        s.cyc   = 1'b0;
        s.stb   = 1'b0;
        if (gnt0) begin
            s.adr   = m0.adr;
            s.dat_w = m0.dat_w;
            s.sel   = m0.sel;
            s.we    = m0.we;
            s.cyc   = m0.cyc & ~tmo_fire;
            s.stb   = m0.stb & ~tmo_fire;
        end else if (gnt1) begin
            s.adr   = m1.adr;
            s.dat_w = m1.dat_w;
            s.sel   = m1.sel;
            s.we    = m1.we;
            s.cyc   = m1.cyc & ~tmo_fire;
            s.stb   = m1.stb & ~tmo_fire;
        end
    end

    // Read data is shared; only ack/err are qualified by ownership.
    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;
    assign m0.ack   = s.ack & gnt0 & m0.stb;
    assign m1.ack   = s.ack & gnt1 & m1.stb;
    assign m0.err   = tmo_fire & gnt0;
    assign m1.err   = tmo_fire & gnt1;
    assign tmo_irq  = tmo_fire;

    // Sticky record of the last address that timed out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_adr <= '0;
        end else if (tmo_fire) begin
            tmo_adr <= s.adr;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;
    import wb_rr_arbiter_pkg::*;

    localparam int unsigned TMO = 16;
    localparam int unsigned TW  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tmo_irq;
    logic [31:0] tmo_adr;

    int checks = 0;
    int errors = 0;

    wb_rr_arbiter_if m0_bus ();
    wb_rr_arbiter_if m1_bus ();
    wb_rr_arbiter_if s_bus ();

    wb_rr_arbiter #(
        .TIMEOUT (TMO),
        .TMO_W   (TW)
    ) dut (
        .clk     (clk),
        .reset   (rst),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .s       (s_bus),
        .tmo_irq (tmo_irq),
        .tmo_adr (tmo_adr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          who;
        logic [31:0] dat;
    } sb_t;

    sb_t sb_q[$];

    typedef struct {
        logic        m1_stb;
        logic        m1_we;
        logic [3:0]  m1_sel;
        logic [31:0] m1_adr;
        logic [31:0] m1_dat;
        logic        m0_stb;
        logic        s_ack;
        logic [31:0] s_dat;
        logic        exp_stb;
        logic        exp_m1_ack;
    } vec_t;

    vec_t tbl[6];

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ack(input int who, input logic [31:0] d);
        sb_t e;
        e.who = who;
        e.dat = d;
        sb_q.push_back(e);
    endtask

    task automatic slave(input logic ack, input logic [31:0] d, input int who);
        s_bus.ack   = ack;
        s_bus.dat_r = d;
        if (ack) expect_ack(who, d);
    endtask

    task automatic set_m(input int who, input logic on, input logic [31:0] adr);
        if (who == 0) begin
            m0_bus.cyc = on; m0_bus.stb = on; m0_bus.adr = adr;
            m0_bus.dat_w = adr ^ 32'h5A5A_5A5A; m0_bus.sel = 4'hF; m0_bus.we = 1'b0;
        end else begin
            m1_bus.cyc = on; m1_bus.stb = on; m1_bus.adr = adr;
            m1_bus.dat_w = adr ^ 32'hA5A5_A5A5; m1_bus.sel = 4'hF; m1_bus.we = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_m(0, 1'b0, 32'h0);
        set_m(1, 1'b0, 32'h0);
        s_bus.ack = 1'b0;
        s_bus.dat_r = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Ack scoreboard: every ack seen by a master must match the oldest expectation.
    always @(negedge clk) begin : mon
        sb_t e;
        if (!rst && (m0_bus.ack === 1'b1 || m1_bus.ack === 1'b1)) begin
            chk1("ack_one_hot", m0_bus.ack & m1_bus.ack, 1'b0);
            if (sb_q.size() == 0) begin
                chk32("ack_unexpected", {30'b0, m1_bus.ack, m0_bus.ack}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk32("ack_who", 32'(m1_bus.ack), e.who);
                chk32("ack_dat", m1_bus.ack ? m1_bus.dat_r : m0_bus.dat_r, e.dat);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;

        tbl[0] = '{1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0000_0011, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 4'h3, 32'h2000_0000, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 4'h3, 32'h2000_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 4'hC, 32'h3000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0055, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 4'h1, 32'hFFFF_FFFC, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'h0000_9999, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 4'hF, 32'h0000_0004, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};

        rst = 1'b1;
        set_m(0, 1'b0, 32'h0);
        set_m(1, 1'b0, 32'h0);
        s_bus.ack = 1'b0;
        s_bus.dat_r = 32'h0;
        s_bus.err = 1'b0;

        // reset state
        #12;
        chk1("rst_s_cyc", s_bus.cyc, 1'b0);
        chk1("rst_s_stb", s_bus.stb, 1'b0);
        chk32("rst_s_adr", s_bus.adr, 32'h0);
        chk1("rst_m0_ack", m0_bus.ack, 1'b0);
        chk1("rst_m1_err", m1_bus.err, 1'b0);
        chk1("rst_irq", tmo_irq, 1'b0);
        chk32("rst_tmo_adr", tmo_adr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // m0 read alone, ack two cycles after stb
        set_m(0, 1'b1, 32'h0000_1000);
        @(negedge clk);
        chk1("a_latency_stb", s_bus.stb, 1'b0);
        @(negedge clk);
        chk1("a_gnt_stb", s_bus.stb, 1'b1);
        chk32("a_gnt_adr", s_bus.adr, 32'h0000_1000);
        tick();
        tick();
        slave(1'b1, 32'hCAFE_0001, 0);
        @(negedge clk);
        chk1("a_m0_ack", m0_bus.ack, 1'b1);
        chk32("a_m0_dat", m0_bus.dat_r, 32'hCAFE_0001);
        chk1("a_m1_ack", m1_bus.ack, 1'b0);
        tick();
        slave(1'b0, 32'h0, 0);
        set_m(0, 1'b0, 32'h0);
        @(negedge clk);
        chk1("a_ack_one_cycle", m0_bus.ack, 1'b0);
        @(negedge clk);
        chk1("a_idle_cyc", s_bus.cyc, 1'b0);

        // routing table with m1 owning the bus (tie after m0 was last owner)
        tick();
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b0; m0_bus.adr = 32'hBAD0_0000;
        m0_bus.dat_w = 32'h0BAD_F00D; m0_bus.sel = 4'h0; m0_bus.we = 1'b1;
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            m1_bus.stb = tbl[i].m1_stb;   m1_bus.we = tbl[i].m1_we;
            m1_bus.sel = tbl[i].m1_sel;   m1_bus.adr = tbl[i].m1_adr;
            m1_bus.dat_w = tbl[i].m1_dat; m0_bus.stb = tbl[i].m0_stb;
            s_bus.ack = tbl[i].s_ack;     s_bus.dat_r = tbl[i].s_dat;
            if (tbl[i].exp_m1_ack) expect_ack(1, tbl[i].s_dat);
            @(negedge clk);
            chk1($sformatf("tbl%0d_s_stb", i), s_bus.stb, tbl[i].exp_stb);
            chk1($sformatf("tbl%0d_s_cyc", i), s_bus.cyc, 1'b1);
            chk1($sformatf("tbl%0d_s_we", i), s_bus.we, tbl[i].m1_we);
            chk32($sformatf("tbl%0d_s_sel", i), 32'(s_bus.sel), 32'(tbl[i].m1_sel));
            chk32($sformatf("tbl%0d_s_adr", i), s_bus.adr, tbl[i].m1_adr);
            chk32($sformatf("tbl%0d_s_dat", i), s_bus.dat_w, tbl[i].m1_dat);
            chk1($sformatf("tbl%0d_m1_ack", i), m1_bus.ack, tbl[i].exp_m1_ack);
            chk1($sformatf("tbl%0d_m0_ack", i), m0_bus.ack, 1'b0);
            chk32($sformatf("tbl%0d_m0_dat", i), m0_bus.dat_r, tbl[i].s_dat);
        end
        tick();
        set_m(0, 1'b0, 32'h0);
        set_m(1, 1'b0, 32'h0);
        slave(1'b0, 32'h0, 0);
        @(negedge clk);

        // simultaneous request after reset: m0 first, then m1 on m0 release
        do_reset();
        set_m(0, 1'b1, 32'h0000_2000);
        set_m(1, 1'b1, 32'h4000_0010);
        @(negedge clk);
        chk1("b_idle_stb", s_bus.stb, 1'b0);
        @(negedge clk);
        chk32("b_first_gnt_adr", s_bus.adr, 32'h0000_2000);
        tick();
        slave(1'b1, 32'hB0B0_0000, 0);
        tick();
        slave(1'b0, 32'h0, 0);
        set_m(0, 1'b0, 32'h0);
        @(negedge clk);
        chk1("b_no_preempt_stb", s_bus.stb, 1'b0);
        @(negedge clk);
        chk32("b_gnt1_adr", s_bus.adr, 32'h4000_0010);
        chk1("b_gnt1_stb", s_bus.stb, 1'b1);
        tick();
        slave(1'b1, 32'hB1B1_0001, 1);
        tick();
        slave(1'b0, 32'h0, 0);
        set_m(1, 1'b0, 32'h0);

        // continuous requests alternate 0,1,0,1
        do_reset();
        set_m(0, 1'b1, 32'h0000_3000);
        set_m(1, 1'b1, 32'h5000_0020);
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            w = i % 2;
            @(negedge clk);
            chk32($sformatf("c_gnt%0d_adr", i), s_bus.adr, (w == 1) ? 32'h5000_0020 : 32'h0000_3000);
            tick();
            slave(1'b1, 32'hC000_0000 + 32'(i), w);
            tick();
            slave(1'b0, 32'h0, 0);
            set_m(w, 1'b0, 32'h0);
            tick();
            set_m(w, 1'b1, (w == 1) ? 32'h5000_0020 : 32'h0000_3000);
        end
        tick();
        set_m(0, 1'b0, 32'h0);
        set_m(1, 1'b0, 32'h0);

        // m1 keeps cyc over three beats while m0 waits
        tick();
        set_m(1, 1'b1, 32'h7000_0000);
        tick();
        set_m(0, 1'b1, 32'h0000_4000);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            m1_bus.adr = 32'h7000_0000 + 32'(4 * k);
            slave(1'b1, 32'hD000_0000 + 32'(k), 1);
            @(negedge clk);
            chk32($sformatf("d_beat%0d_adr", k), s_bus.adr, 32'h7000_0000 + 32'(4 * k));
            chk1($sformatf("d_beat%0d_m0_ack", k), m0_bus.ack, 1'b0);
        end
        tick();
        slave(1'b0, 32'h0, 0);
        set_m(1, 1'b0, 32'h7000_0008);
        @(negedge clk);
        chk1("d_wait_stb", s_bus.stb, 1'b0);
        @(negedge clk);
        chk32("d_gnt0_adr", s_bus.adr, 32'h0000_4000);
        chk1("d_gnt0_stb", s_bus.stb, 1'b1);
        tick();
        slave(1'b1, 32'hD0D0_0003, 0);
        tick();
        slave(1'b0, 32'h0, 0);
        set_m(0, 1'b0, 32'h0);

        // slave never acks m1: abort exactly on stb cycle TMO
        tick();
        set_m(1, 1'b1, 32'h6000_0004);
        chk32("e_tmo_adr_before", tmo_adr, 32'h0);
        @(posedge clk);
        for (int k = 1; k <= int'(TMO); k++) begin
            @(negedge clk);
            chk1($sformatf("e_err_c%0d", k), m1_bus.err, k == int'(TMO));
            chk1($sformatf("e_irq_c%0d", k), tmo_irq, k == int'(TMO));
            chk1($sformatf("e_stb_c%0d", k), s_bus.stb, k != int'(TMO));
            if (k == int'(TMO)) begin
                chk1("e_cyc_abort", s_bus.cyc, 1'b0);
                chk1("e_m0_err", m0_bus.err, 1'b0);
            end
        end
        tick();
        set_m(1, 1'b0, 32'h0);
        @(negedge clk);
        chk32("e_tmo_adr", tmo_adr, 32'h6000_0004);
        chk1("e_irq_pulse", tmo_irq, 1'b0);
        chk1("e_err_pulse", m1_bus.err, 1'b0);

        // ack lands on the terminal-count cycle: ack wins
        tick();
        set_m(0, 1'b1, 32'h0000_5000);
        @(posedge clk);
        repeat (TMO - 1) @(posedge clk);
        #1;
        slave(1'b1, 32'hF00D_0001, 0);
        @(negedge clk);
        chk1("f_no_err", m0_bus.err, 1'b0);
        chk1("f_no_irq", tmo_irq, 1'b0);
        chk1("f_ack", m0_bus.ack, 1'b1);
        chk1("f_stb", s_bus.stb, 1'b1);
        tick();
        slave(1'b0, 32'h0, 0);
        set_m(0, 1'b0, 32'h0);
        @(negedge clk);
        chk32("f_tmo_adr_sticky", tmo_adr, 32'h6000_0004);

        // asynchronous reset in the middle of a GNT0 transfer
        tick();
        set_m(0, 1'b1, 32'h0000_6000);
        @(posedge clk);
        @(negedge clk);
        chk1("g_pre_stb", s_bus.stb, 1'b1);
        #1;
        s_bus.ack = 1'b1;
        #1;
        chk1("g_pre_ack", m0_bus.ack, 1'b1);
        rst = 1'b1;
        #1;
        chk1("g_s_cyc", s_bus.cyc, 1'b0);
        chk1("g_s_stb", s_bus.stb, 1'b0);
        chk32("g_s_adr", s_bus.adr, 32'h0);
        chk32("g_s_dat", s_bus.dat_w, 32'h0);
        chk32("g_s_sel", 32'(s_bus.sel), 32'h0);
        chk1("g_m0_ack", m0_bus.ack, 1'b0);
        chk1("g_m0_err", m0_bus.err, 1'b0);
        chk1("g_irq", tmo_irq, 1'b0);
        chk32("g_tmo_adr", tmo_adr, 32'h0);
        s_bus.ack = 1'b0;
        @(negedge clk);
        chk1("g_hold_idle", s_bus.cyc, 1'b0);
        tick();
        rst = 1'b0;
        set_m(0, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);

        chk32("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
